psg_write_scheduler: RTL and testbench

//  Arbitrates PSG register writes from NUM_REQ requesters (CPU bus, sequencer DMA, ...) into one write FIFO.

---
 rtl/psg_pkg.sv | 17 +
 rtl/psg_wr_fifo.sv | 78 +++++++
 rtl/psg_write_scheduler.sv | 154 +++++++++++++++
 tb/tb_psg_write_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psg_pkg.sv
// Shared types for the PSG write scheduler: write entry layout and commit FSM states.
package psg_pkg;

    localparam int PSG_ADDR_W = 4;
    localparam int PSG_DATA_W = 8;

    typedef struct packed {
        logic [PSG_ADDR_W-1:0] addr;
        logic [PSG_DATA_W-1:0] data;
    } psg_wr_t;

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } psg_sched_state_t;

endpackage

// File: rtl/psg_wr_fifo.sv
// Synchronous write FIFO of psg_wr_t entries. Full, empty and level are registered,
// so a pop in the same cycle never frees a slot for a push until the next cycle.
module psg_wr_fifo
    import psg_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  psg_wr_t          wr_entry,
    output psg_wr_t          head,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    psg_wr_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    // Next pointer/level/flag values; flush discards everything queued.
    always_comb begin
        do_push  = push && !full_q && !flush;
        do_pop   = pop && !empty_q && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
        end
        full_d  = (level_d == LVL_W'(DEPTH));
        empty_d = (level_d == '0);
    end

    // Pointer and status registers.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign level = level_q;

endmodule

// File: rtl/psg_write_scheduler.sv
// Round-robin arbitration of PSG register writes into a FIFO, committed to the PSG
// core only on divider strobes with a configurable number of skipped strobes per commit.
//
//   state | meaning
//   IDLE  | next strobe commits the FIFO head if one is queued
//   GAP   | strobes are counted down and ignored after a commit
module psg_write_scheduler
    import psg_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = PSG_ADDR_W,
    parameter int DATA_W      = PSG_DATA_W,
    parameter int FIFO_DEPTH  = 8,
    parameter int GAP_STROBES = 1
) (
    input  logic                        clk_in,
    input  logic                        reset,
    input  logic                        strobe_in,
    input  logic                        flush,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic                        psg_we,
    output logic [ADDR_W-1:0]           psg_addr,
    output logic [DATA_W-1:0]           psg_wdata,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAP_W = (GAP_STROBES > 0) ? $clog2(GAP_STROBES + 1) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [RR_W-1:0]   rr_q, rr_d;
    logic [RR_W-1:0]   grant_idx;
    logic              grant_any;
    logic [NUM_REQ-1:0] grant;
    int                cand;
    psg_wr_t           push_entry;
    psg_wr_t           fifo_head;
    logic              fifo_full, fifo_empty;
    logic              pop;

    psg_sched_state_t  state_q, state_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              psg_we_q, psg_we_d;
    logic [ADDR_W-1:0] psg_addr_q, psg_addr_d;
    logic [DATA_W-1:0] psg_wdata_q, psg_wdata_d;

    // Round-robin grant: first valid requester at or after the pointer, only with room.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        if (!reset && !fifo_full && !flush) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand = int'(rr_q) + i;
                if (cand >= NUM_REQ) cand = cand - NUM_REQ;
                if (!grant_any && req_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = RR_W'(cand);
                end
            end
        end
        if (grant_any) grant[grant_idx] = 1'b1;
        rr_d = rr_q;
        if (grant_any) rr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + RR_W'(1);
        push_entry.addr = req_addr[grant_idx*ADDR_W +: ADDR_W];
        push_entry.data = req_data[grant_idx*DATA_W +: DATA_W];
    end

    assign req_ready = grant;

    // Arbiter pointer survives flush; only reset returns it to requester 0.
    always_ff @(posedge clk_in) begin
        if (reset) rr_q <= '0;
        else       rr_q <= rr_d;
    end

    psg_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk_in   (clk_in),
        .reset    (reset),
        .flush    (flush),
        .push     (grant_any),
        .pop      (pop),
        .wr_entry (push_entry),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    // Commit decision: pop on an eligible strobe, then count off the skipped strobes.
    always_comb begin
        pop         = 1'b0;
        state_d     = state_q;
        gap_cnt_d   = gap_cnt_q;
        psg_we_d    = 1'b0;
        psg_addr_d  = psg_addr_q;
        psg_wdata_d = psg_wdata_q;
        if (flush) begin
            state_d   = IDLE;
            gap_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (strobe_in && !fifo_empty) begin
                        pop         = 1'b1;
                        psg_we_d    = 1'b1;
                        psg_addr_d  = fifo_head.addr;
                        psg_wdata_d = fifo_head.data;
                        if (GAP_STROBES > 0) begin
                            gap_cnt_d = GAP_W'(GAP_STROBES);
                            state_d   = GAP;
                        end
                    end
                end
                GAP: begin
                    if (strobe_in) begin
                        gap_cnt_d = gap_cnt_q - GAP_W'(1);
                        if (gap_cnt_q == GAP_W'(1)) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM state, gap counter and registered PSG-side outputs.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= IDLE;
            gap_cnt_q   <= '0;
            psg_we_q    <= 1'b0;
            psg_addr_q  <= '0;
            psg_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            psg_we_q    <= psg_we_d;
            psg_addr_q  <= psg_addr_d;
            psg_wdata_q <= psg_wdata_d;
        end
    end

    assign psg_we    = psg_we_q;
    assign psg_addr  = psg_addr_q;
    assign psg_wdata = psg_wdata_q;

endmodule

// File: tb/tb_psg_write_scheduler.sv
// Bench for psg_write_scheduler: directed scenarios plus a randomized run, all checked
// against a queue-based model of the scheduler's rules.
module tb_psg_write_scheduler;

    localparam int NR    = 2;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int GAPS  = 1;

    logic              clk_in = 1'b0;
    logic              reset, strobe_in, flush;
    logic [NR-1:0]     req_valid, req_ready;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic              psg_we;
    logic [AW-1:0]     psg_addr;
    logic [DW-1:0]     psg_wdata;
    logic [3:0]        fifo_level;

    always #5 clk_in = ~clk_in;

    psg_write_scheduler #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .GAP_STROBES(GAPS)
    ) dut (
        .clk_in(clk_in), .reset(reset), .strobe_in(strobe_in), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
        .psg_we(psg_we), .psg_addr(psg_addr), .psg_wdata(psg_wdata), .fifo_level(fifo_level)
    );

    int          n_err = 0;
    int          n_chk = 0;
    logic [11:0] src[NR][$];
    logic [11:0] mq[$];
    logic [11:0] acc_log[$];
    logic [11:0] com_log[$];
    int          m_rr, m_skip;
    logic        m_we;
    logic [3:0]  m_addr;
    logic [7:0]  m_data;
    logic [NR-1:0] obs_ready, exp_ready;
    bit          withdraw_en = 1'b0;

    // One clock of stimulus plus the reference model update for that clock.
    task automatic step(input bit stb, input bit fl, input bit rs);
        logic [11:0] ent;
        int g, idx;
        bit v;
        strobe_in = stb; flush = fl; reset = rs;
        for (int r = 0; r < NR; r++) begin
            v = (src[r].size() > 0);
            if (withdraw_en && $urandom_range(0, 3) == 0) v = 1'b0;
            req_valid[r] = v;
            if (src[r].size() > 0) begin
                req_addr[r*AW +: AW] = src[r][0][11:8];
                req_data[r*DW +: DW] = src[r][0][7:0];
            end
        end
        @(negedge clk_in);
        obs_ready = req_ready;
        g = -1;
        exp_ready = '0;
        if (!rs && !fl && mq.size() < DEPTH)
            for (int i = 0; i < NR; i++) begin
                idx = (m_rr + i) % NR;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        if (g >= 0) exp_ready[g] = 1'b1;
        for (int r = 0; r < NR; r++)
            if (req_valid[r] && obs_ready[r]) begin
                acc_log.push_back(src[r][0]);
                void'(src[r].pop_front());
            end
        m_we = 1'b0;
        if (rs) begin
            mq.delete(); m_rr = 0; m_skip = 0; m_addr = '0; m_data = '0;
        end else if (fl) begin
            mq.delete(); m_skip = 0;
        end else begin
            if (stb) begin
                if (m_skip > 0) m_skip--;
                else if (mq.size() > 0) begin
                    ent = mq.pop_front();
                    m_we = 1'b1; m_addr = ent[11:8]; m_data = ent[7:0]; m_skip = GAPS;
                end
            end
            if (g >= 0) begin
                mq.push_back({req_addr[g*AW +: AW], req_data[g*DW +: DW]});
                m_rr = (g + 1) % NR;
            end
        end
        @(posedge clk_in);
        #1;
        if (psg_we) com_log.push_back({psg_addr, psg_wdata});
    endtask

    task automatic clear_all();
        for (int r = 0; r < NR; r++) src[r].delete();
        acc_log.delete();
        com_log.delete();
        step(0, 0, 1);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin
            src[0].push_back({4'(i), 8'(8'h30 + i)});
            src[1].push_back({4'(i + 8), 8'(8'h50 + i)});
        end
        step(0, 0, 1);
        for (int k = 0; k < 6; k++) begin
            step(k[0], 0, 0);
            n_chk++;
            if ({psg_we, psg_addr, psg_wdata, fifo_level} !== {m_we, m_addr, m_data, 4'(mq.size())}) begin
                n_err++; $display("FAIL reset_traffic out: got %h exp %h",
                    {psg_we, psg_addr, psg_wdata, fifo_level}, {m_we, m_addr, m_data, 4'(mq.size())});
            end
        end
        step(1, 0, 1);
        n_chk++;
        if (obs_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b exp 00", obs_ready); end
        step(1, 0, 1);
        n_chk++;
        if ({psg_we, psg_addr, psg_wdata, fifo_level} !== 17'h0) begin
            n_err++; $display("FAIL reset_outputs: got %h exp 0", {psg_we, psg_addr, psg_wdata, fifo_level});
        end
        step(0, 0, 0);
        n_chk++;
        if (obs_ready !== 2'b01) begin n_err++; $display("FAIL reset_first_ready: got %b exp 01", obs_ready); end
    endtask

    task automatic test_single();
        int nwe = 0, we_k = -1;
        clear_all();
        src[0].push_back(12'h738);
        for (int k = 0; k < 60; k++) begin
            step(k % 28 == 27, 0, 0);
            n_chk++;
            if ({psg_we, psg_addr, psg_wdata, fifo_level} !== {m_we, m_addr, m_data, 4'(mq.size())}) begin
                n_err++; $display("FAIL single out k=%0d: got %h exp %h", k,
                    {psg_we, psg_addr, psg_wdata, fifo_level}, {m_we, m_addr, m_data, 4'(mq.size())});
            end
            if (psg_we) begin nwe++; we_k = k; end
        end
        n_chk++;
        if (nwe != 1 || we_k != 27) begin
            n_err++; $display("FAIL single_we: got count %0d after strobe cycle %0d, exp 1 after 27", nwe, we_k);
        end
        n_chk++;
        if (com_log.size() != 1 || com_log[0] !== 12'h738) begin
            n_err++; $display("FAIL single_data: got %0d entries first %h exp 738", com_log.size(),
                com_log.size() > 0 ? com_log[0] : 12'hxxx);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d[8] = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};
        int sidx = 0;
        int cs[$];
        clear_all();
        for (int i = 0; i < 4; i++) begin
            src[0].push_back({4'(i), 8'(8'h10 + i)});
            src[1].push_back({4'(i + 8), 8'(8'h20 + i)});
        end
        for (int k = 0; k < 100; k++) begin
            step(k % 4 == 3, 0, 0);
            n_chk++;
            if (obs_ready !== exp_ready) begin
                n_err++; $display("FAIL rr ready k=%0d: got %b exp %b", k, obs_ready, exp_ready);
            end
            n_chk++;
            if ({psg_we, psg_addr, psg_wdata, fifo_level} !== {m_we, m_addr, m_data, 4'(mq.size())}) begin
                n_err++; $display("FAIL rr out k=%0d: got %h exp %h", k,
                    {psg_we, psg_addr, psg_wdata, fifo_level}, {m_we, m_addr, m_data, 4'(mq.size())});
            end
            if (psg_we) cs.push_back(sidx);
            if (k % 4 == 3) sidx++;
        end
        n_chk++;
        if (acc_log.size() != 8 || com_log.size() != 8) begin
            n_err++; $display("FAIL rr_counts: got acc %0d com %0d exp 8 8", acc_log.size(), com_log.size());
        end else
            for (int i = 0; i < 8; i++) begin
                n_chk++;
                if (acc_log[i][7:0] !== exp_d[i] || com_log[i][7:0] !== exp_d[i]) begin
                    n_err++; $display("FAIL rr_order[%0d]: got acc %h com %h exp %h",
                        i, acc_log[i][7:0], com_log[i][7:0], exp_d[i]);
                end
            end
        for (int i = 1; i < cs.size(); i++) begin
            n_chk++;
            if (cs[i] - cs[i-1] != 1 + GAPS) begin
                n_err++; $display("FAIL rr_spacing[%0d]: got %0d strobes exp %0d", i, cs[i] - cs[i-1], 1 + GAPS);
            end
        end
    endtask

    task automatic test_full();
        clear_all();
        for (int i = 0; i < 10; i++) src[0].push_back({4'(i), 8'(8'h40 + i)});
        for (int k = 0; k < 12; k++) step(0, 0, 0);
        n_chk++;
        if (acc_log.size() != 8 || fifo_level !== 4'd8 || obs_ready !== 2'b00 || src[0].size() != 2) begin
            n_err++; $display("FAIL full: got acc %0d level %0d ready %b left %0d exp 8 8 00 2",
                acc_log.size(), fifo_level, obs_ready, src[0].size());
        end
        step(1, 0, 0);
        n_chk++;
        if (psg_we !== 1'b1 || fifo_level !== 4'd7 || obs_ready !== 2'b00) begin
            n_err++; $display("FAIL full_pop: got we %b level %0d ready %b exp 1 7 00", psg_we, fifo_level, obs_ready);
        end
        step(0, 0, 0);
        n_chk++;
        if (obs_ready !== 2'b01 || psg_we !== 1'b0) begin
            n_err++; $display("FAIL full_reopen: got ready %b we %b exp 01 0", obs_ready, psg_we);
        end
        for (int k = 0; k < 40; k++) begin
            step(1, 0, 0);
            n_chk++;
            if ({psg_we, psg_addr, psg_wdata, fifo_level} !== {m_we, m_addr, m_data, 4'(mq.size())}) begin
                n_err++; $display("FAIL full_drain k=%0d: got %h exp %h", k,
                    {psg_we, psg_addr, psg_wdata, fifo_level}, {m_we, m_addr, m_data, 4'(mq.size())});
            end
        end
        n_chk++;
        if (com_log.size() != 10) begin
            n_err++; $display("FAIL full_lost: got %0d commits exp 10", com_log.size());
        end else
            for (int i = 0; i < 10; i++) begin
                n_chk++;
                if (com_log[i] !== {4'(i), 8'(8'h40 + i)}) begin
                    n_err++; $display("FAIL full_order[%0d]: got %h exp %h", i, com_log[i], {4'(i), 8'(8'h40 + i)});
                end
            end
    endtask

    task automatic test_race();
        clear_all();
        src[0].push_back(12'h5a5);
        step(1, 0, 0);
        n_chk++;
        if (psg_we !== 1'b0 || fifo_level !== 4'd1) begin
            n_err++; $display("FAIL race_same_cycle: got we %b level %0d exp 0 1", psg_we, fifo_level);
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0);
            n_chk++;
            if (psg_we !== 1'b0) begin n_err++; $display("FAIL race_idle k=%0d: got we %b exp 0", k, psg_we); end
        end
        step(1, 0, 0);
        n_chk++;
        if (psg_we !== 1'b1 || psg_addr !== 4'h5 || psg_wdata !== 8'ha5 || fifo_level !== 4'd0) begin
            n_err++; $display("FAIL race_commit: got we %b addr %h data %h level %0d exp 1 5 a5 0",
                psg_we, psg_addr, psg_wdata, fifo_level);
        end
    endtask

    task automatic test_flush();
        clear_all();
        for (int i = 0; i < 5; i++) src[0].push_back({4'(i), 8'(8'h60 + i)});
        for (int k = 0; k < 5; k++) step(0, 0, 0);
        n_chk++;
        if (fifo_level !== 4'd5) begin n_err++; $display("FAIL flush_pre level: got %0d exp 5", fifo_level); end
        step(1, 1, 0);
        n_chk++;
        if (psg_we !== 1'b0 || fifo_level !== 4'd0) begin
            n_err++; $display("FAIL flush: got we %b level %0d exp 0 0", psg_we, fifo_level);
        end
        acc_log.delete();
        com_log.delete();
        src[0].push_back(12'h170);
        src[1].push_back(12'h280);
        for (int k = 0; k < 20; k++) begin
            step(k % 3 == 2, 0, 0);
            n_chk++;
            if ({psg_we, psg_addr, psg_wdata, fifo_level} !== {m_we, m_addr, m_data, 4'(mq.size())}) begin
                n_err++; $display("FAIL flush_resume k=%0d: got %h exp %h", k,
                    {psg_we, psg_addr, psg_wdata, fifo_level}, {m_we, m_addr, m_data, 4'(mq.size())});
            end
        end
        n_chk++;
        if (com_log.size() != 2 || com_log[0] !== 12'h280 || com_log[1] !== 12'h170) begin
            n_err++; $display("FAIL flush_rr_kept: got %0d commits first %h exp 280 then 170",
                com_log.size(), com_log.size() > 0 ? com_log[0] : 12'hxxx);
        end
    endtask

    task automatic test_random();
        clear_all();
        withdraw_en = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            for (int r = 0; r < NR; r++)
                if (src[r].size() < 3 && $urandom_range(0, 1) == 1) src[r].push_back(12'($urandom));
            step($urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0, $urandom_range(0, 299) == 0);
            n_chk++;
            if (obs_ready !== exp_ready) begin
                n_err++; $display("FAIL rand ready k=%0d: got %b exp %b", k, obs_ready, exp_ready);
            end
            n_chk++;
            if ({psg_we, psg_addr, psg_wdata, fifo_level} !== {m_we, m_addr, m_data, 4'(mq.size())}) begin
                n_err++; $display("FAIL rand out k=%0d: got %h exp %h", k,
                    {psg_we, psg_addr, psg_wdata, fifo_level}, {m_we, m_addr, m_data, 4'(mq.size())});
            end
        end
        withdraw_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; strobe_in = 1'b0; flush = 1'b0;
        req_valid = '0; req_addr = '0; req_data = '0;
        m_rr = 0; m_skip = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_race();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
